// File: rtl/bit_reorder_stream.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed sample order
// (e.g. from a radix-2 FFT) and leave in natural index order.
module bit_reorder_stream #(
   parameter string ARCHITECTURE = "BEHAVIORAL",
   parameter int    DATA_WIDTH   = 32,
   parameter int    FRAME_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int N = 1 << FRAME_LOG2;
   localparam logic [FRAME_LOG2-1:0] LAST_IDX = FRAME_LOG2'(N - 1);

   generate
      if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
         logic [DATA_WIDTH-1:0] mem [2][N];
         logic [1:0]            full;
         logic                  wb;
         logic                  rb;
         logic [FRAME_LOG2-1:0] wr_cnt;
         logic [FRAME_LOG2-1:0] rd_cnt;
         logic [FRAME_LOG2-1:0] wr_addr;
         logic [DATA_WIDTH-1:0] data_q;
         logic                  valid_q;
         logic                  last_q;
         logic                  wr_fire;
         logic                  load;

         // Writing sample k to slot bitrev(k) is what restores natural order on readout.
         always_comb begin
            wr_addr = '0;
            for (int i = 0; i < FRAME_LOG2; i++) begin
               wr_addr[i] = wr_cnt[FRAME_LOG2-1-i];
            end
         end

         assign in_ready = rst_n && !full[wb];
         assign wr_fire  = in_valid && in_ready;
         assign load     = full[rb] && (!valid_q || out_ready);

         always_ff @(posedge clk) begin
            if (wr_fire) begin
               mem[wb][wr_addr] <= in_data;
            end
         end

         // Write and read sides never own the same bank, so both flag updates can land together.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wb      <= 1'b0;
               rb      <= 1'b0;
               wr_cnt  <= '0;
               rd_cnt  <= '0;
               full    <= 2'b00;
               data_q  <= '0;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end else begin
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_IDX) begin
                     full[wb] <= 1'b1;
                     wb       <= ~wb;
                  end
               end
               if (load) begin
                  data_q  <= mem[rb][rd_cnt];
                  last_q  <= (rd_cnt == LAST_IDX);
                  valid_q <= 1'b1;
                  rd_cnt  <= rd_cnt + 1'b1;
                  if (rd_cnt == LAST_IDX) begin
                     full[rb] <= 1'b0;
                     rb       <= ~rb;
                  end
               end else if (valid_q && out_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
         end

         assign out_data  = data_q;
         assign out_valid = valid_q;
         assign out_last  = last_q;
      end else begin : g_reserved
         // Vendor-specific variants are reserved; they present an idle block.
         assign in_ready  = 1'b0;
         assign out_data  = '0;
         assign out_valid = 1'b0;
         assign out_last  = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_bit_reorder_stream.sv
// Directed bench for bit_reorder_stream: an 8-sample instance for the main
// scenarios and a 2-sample instance for the minimum frame size.
module tb_bit_reorder_stream;

   logic        clk;
   logic        rst_n;

   logic [31:0] a_in_data;
   logic        a_in_valid;
   logic        a_in_ready;
   logic [31:0] a_out_data;
   logic        a_out_valid;
   logic        a_out_ready;
   logic        a_out_last;

   logic [31:0] b_in_data;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [31:0] b_out_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic        b_out_last;

   int          total;
   int          bad;

   logic [31:0] in_q[$];
   logic [31:0] exp_d[$];
   logic        exp_l[$];
   bit          stalled;
   logic [31:0] held_d;
   logic        held_l;
   logic [31:0] sf_vec [8];

   bit_reorder_stream #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(32), .FRAME_LOG2(3)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (a_in_data),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .out_data  (a_out_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_last  (a_out_last)
   );

   bit_reorder_stream #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(32), .FRAME_LOG2(1)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (b_in_data),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .out_data  (b_out_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_last  (b_out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs arrive in bit-reversed order; the consumer must see base+0 .. base+7.
   task automatic pushFrame(input logic [31:0] base);
      for (int k = 0; k < 8; k++) begin
         in_q.push_back(base + 32'(bitrev3(3'(k))));
      end
      for (int i = 0; i < 8; i++) begin
         exp_d.push_back(base + 32'(i));
         exp_l.push_back(i == 7);
      end
   endtask

   task automatic applyStimulus(input int cycles, input int vpct, input int rpct,
                                input bit until_drained, input bit expect_ready,
                                input bit gapfree);
      bit in_fire;
      bit seen_out;
      seen_out = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         if (until_drained && exp_d.size() == 0) break;
         if (stalled) begin
            checkOutput("hold_valid", 32'(a_out_valid), 32'd1);
            checkOutput("hold_data", a_out_data, held_d);
            checkOutput("hold_last", 32'(a_out_last), 32'(held_l));
         end
         a_in_valid  = (in_q.size() > 0) && ($urandom_range(99) < vpct);
         a_in_data   = (in_q.size() > 0) ? in_q[0] : 32'd0;
         a_out_ready = ($urandom_range(99) < rpct);
         if (expect_ready && in_q.size() > 0) begin
            checkOutput("in_ready_stream", 32'(a_in_ready), 32'd1);
         end
         if (gapfree && seen_out && exp_d.size() > 0) begin
            checkOutput("gap_free", 32'(a_out_valid), 32'd1);
         end
         if (a_out_valid && a_out_ready) begin
            seen_out = 1'b1;
            if (exp_d.size() == 0) begin
               checkOutput("extra_out", 32'(a_out_valid), 32'd0);
            end else begin
               checkOutput("out_data", a_out_data, exp_d.pop_front());
               checkOutput("out_last", 32'(a_out_last), 32'(exp_l.pop_front()));
            end
         end
         stalled = a_out_valid && !a_out_ready;
         held_d  = a_out_data;
         held_l  = a_out_last;
         in_fire = a_in_valid && a_in_ready;
         tick();
         if (in_fire) void'(in_q.pop_front());
      end
      a_in_valid = 1'b0;
      if (until_drained) begin
         checkOutput("drain_left", 32'(exp_d.size()), 32'd0);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      stalled = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      sf_vec = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
      rst_n = 1'b0;
      a_in_data = '0;
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      b_in_data = '0;
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;

      // Reset values on both instances
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(a_in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("rst_out_last", 32'(a_out_last), 32'd0);
      checkOutput("rst_out_data", a_out_data, 32'd0);
      checkOutput("rst_b_in_ready", 32'(b_in_ready), 32'd0);
      checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rel_in_ready", 32'(a_in_ready), 32'd1);
      checkOutput("rel_b_in_ready", 32'(b_in_ready), 32'd1);

      // Minimum frame size: A,B in, A,B out with last on B
      b_in_valid = 1'b1;
      b_in_data = 32'hAAAA_0001;
      tick();
      b_in_data = 32'hBBBB_0002;
      tick();
      b_in_valid = 1'b0;
      checkOutput("min_pre_valid", 32'(b_out_valid), 32'd0);
      tick();
      checkOutput("min_a_valid", 32'(b_out_valid), 32'd1);
      checkOutput("min_a_data", b_out_data, 32'hAAAA_0001);
      checkOutput("min_a_last", 32'(b_out_last), 32'd0);
      tick();
      checkOutput("min_b_valid", 32'(b_out_valid), 32'd1);
      checkOutput("min_b_data", b_out_data, 32'hBBBB_0002);
      checkOutput("min_b_last", 32'(b_out_last), 32'd1);
      tick();
      checkOutput("min_idle", 32'(b_out_valid), 32'd0);

      // Single frame: exact latency and last marking
      a_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_in_valid = 1'b1;
         a_in_data = sf_vec[k];
         checkOutput("sf_in_ready", 32'(a_in_ready), 32'd1);
         checkOutput("sf_no_early", 32'(a_out_valid), 32'd0);
         tick();
      end
      a_in_valid = 1'b0;
      checkOutput("sf_lat_pre", 32'(a_out_valid), 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         checkOutput("sf_valid", 32'(a_out_valid), 32'd1);
         checkOutput("sf_data", a_out_data, 32'(i));
         checkOutput("sf_last", 32'(a_out_last), 32'(i == 7));
         tick();
      end
      checkOutput("sf_idle", 32'(a_out_valid), 32'd0);

      // Back-to-back frames at full rate
      $display("[TB] back-to-back");
      for (int f = 1; f <= 4; f++) pushFrame(32'(f) << 8);
      applyStimulus(100, 100, 100, 1'b1, 1'b1, 1'b1);

      // Backpressure: two frames fill both banks, third stalls
      $display("[TB] backpressure");
      pushFrame(32'h0001_1000);
      pushFrame(32'h0001_2000);
      pushFrame(32'h0001_3000);
      applyStimulus(40, 100, 0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_in_ready", 32'(a_in_ready), 32'd0);
      checkOutput("bp_accepted", 32'(in_q.size()), 32'd8);
      checkOutput("bp_head_valid", 32'(a_out_valid), 32'd1);
      checkOutput("bp_head_data", a_out_data, 32'h0001_1000);
      applyStimulus(200, 100, 100, 1'b1, 1'b0, 1'b0);

      // Random-ish valid/ready at 50%
      $display("[TB] random handshake");
      for (int f = 0; f < 5; f++) pushFrame(32'h0002_0000 + (32'(f) << 8));
      applyStimulus(1000, 50, 50, 1'b1, 1'b0, 1'b0);

      // Reset with frame 1 half read and frame 2 partially written
      $display("[TB] mid-operation reset");
      pushFrame(32'h0003_0900);
      for (int k = 0; k < 3; k++) in_q.push_back(32'h0003_0A00 + 32'(bitrev3(3'(k))));
      applyStimulus(11, 100, 100, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      checkOutput("mr_in_ready", 32'(a_in_ready), 32'd0);
      checkOutput("mr_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("mr_out_last", 32'(a_out_last), 32'd0);
      checkOutput("mr_out_data", a_out_data, 32'd0);
      in_q.delete();
      exp_d.delete();
      exp_l.delete();
      stalled = 1'b0;
      rst_n = 1'b1;
      tick();
      checkOutput("mr_rel_ready", 32'(a_in_ready), 32'd1);
      pushFrame(32'h0004_0B00);
      applyStimulus(100, 100, 100, 1'b1, 1'b1, 1'b0);
      applyStimulus(6, 0, 100, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_no_stale", 32'(a_out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
